elastic_pipe: RTL

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/elastic_pipe.sv | 72 +++++++
 1 files changed

// File: rtl/elastic_pipe.sv
// Elastic register pipeline with valid/ready handshake, bubble collapsing,
// synchronous flush and an occupancy count.
module elastic_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;

    // A stage advances when any stage downstream of it is empty, or the
    // output is being accepted; written flat to avoid a combinational chain.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            adv[i] = out_ready;
            for (int j = i + 1; j < DEPTH; j++) begin
                if (!v[j]) adv[i] = 1'b1;
            end
        end
        load = ~v | adv;
    end

    assign in_ready  = load[0] && !flush && !reset;
    assign out_valid = v[DEPTH-1] && !flush && !reset;
    assign out_data  = d[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(v[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v[0] <= 1'b0;
            d[0] <= RESET_VAL;
        end else if (load[0]) begin
            v[0] <= in_valid;
            d[0] <= in_data;
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                v[g] <= 1'b0;
                d[g] <= RESET_VAL;
            end else if (load[g]) begin
                v[g] <= v[g-1];
                d[g] <= d[g-1];
            end
        end
    end

endmodule
